prefetch_ar_arbiter: RTL and testbench



---
 rtl/prefetch_ar_arbiter_if.sv | 55 +++++
 rtl/prefetch_ar_arbiter.sv | 123 ++++++++++++
 tb/tb_prefetch_ar_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefetch_ar_arbiter_if.sv
// AXI read-path bundle: NUM_REQ requester AR/R channels plus the single DDR-side AR/R master channel.
interface prefetch_ar_arbiter_if #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_BITS       = 16,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 8
);
    logic [NUM_REQ-1:0]                 s_ar_valid;
    logic [NUM_REQ-1:0]                 s_ar_ready;
    logic [NUM_REQ*ADDR_BITS-1:0]       s_ar_addr;
    logic [NUM_REQ*BURST_LEN_WIDTH-1:0] s_ar_len;
    logic [NUM_REQ*TID_WIDTH-1:0]       s_ar_id;

    logic                               m_ar_valid;
    logic                               m_ar_ready;
    logic [ADDR_BITS-1:0]               m_ar_addr;
    logic [BURST_LEN_WIDTH-1:0]         m_ar_len;
    logic [TID_WIDTH-1:0]               m_ar_id;

    logic                               m_r_valid;
    logic                               m_r_ready;
    logic [DATA_WIDTH-1:0]              m_r_data;
    logic                               m_r_last;
    logic [TID_WIDTH-1:0]               m_r_id;

    logic [NUM_REQ-1:0]                 s_r_valid;
    logic [NUM_REQ-1:0]                 s_r_ready;
    logic [DATA_WIDTH-1:0]              s_r_data;
    logic                               s_r_last;
    logic [TID_WIDTH-1:0]               s_r_id;

    // The arbiter sits on the master side of this bundle; requesters and DDR on the slave side.
    modport master (
        input  s_ar_valid, s_ar_addr, s_ar_len, s_ar_id,
        output s_ar_ready,
        output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id,
        input  m_ar_ready,
        input  m_r_valid, m_r_data, m_r_last, m_r_id,
        output m_r_ready,
        output s_r_valid, s_r_data, s_r_last, s_r_id,
        input  s_r_ready
    );

    modport slave (
        output s_ar_valid, s_ar_addr, s_ar_len, s_ar_id,
        input  s_ar_ready,
        input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id,
        output m_ar_ready,
        output m_r_valid, m_r_data, m_r_last, m_r_id,
        input  m_r_ready,
        input  s_r_valid, s_r_data, s_r_last, s_r_id,
        output s_r_ready
    );
endinterface

// File: rtl/prefetch_ar_arbiter.sv
// Shares one DDR AXI read path between NUM_REQ requesters: arbitrates AR, records grant order,
// and steers in-order R bursts back to their issuers.
module prefetch_ar_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_BITS       = 16,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int LOG_OUTSTANDING = 2,
    parameter int PRIO0           = 1
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     en,
    prefetch_ar_arbiter_if.master    bus,
    output logic [LOG_OUTSTANDING:0] outstandingCnt,
    output logic                     errUnexpectedR
);
    localparam int DEPTH = 1 << LOG_OUTSTANDING;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [LOG_OUTSTANDING:0] FULL_CNT = (LOG_OUTSTANDING+1)'(DEPTH);

    logic [IDX_W-1:0]           rr_ptr;
    logic [IDX_W-1:0]           winner;
    logic [IDX_W-1:0]           head;
    logic                       found;
    logic                       via_prio;
    logic                       can_grant;
    logic                       ar_hs;
    logic                       r_pop;
    logic                       fifo_empty;
    logic [IDX_W-1:0]           order_fifo [DEPTH];
    logic [LOG_OUTSTANDING-1:0] wr_ptr;
    logic [LOG_OUTSTANDING-1:0] rd_ptr;

    // Requester 0 may pre-empt the rotation; otherwise scan upward from the last round-robin winner.
    always_comb begin
        logic [IDX_W:0] cand;
        cand     = '0;
        winner   = '0;
        found    = 1'b0;
        via_prio = 1'b0;
        if (PRIO0 != 0 && bus.s_ar_valid[0]) begin
            found    = 1'b1;
            via_prio = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(NUM_REQ))
                    cand = cand - (IDX_W+1)'(NUM_REQ);
                if (!found && bus.s_ar_valid[cand[IDX_W-1:0]]) begin
                    winner = cand[IDX_W-1:0];
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        can_grant      = en && (!bus.m_ar_valid || bus.m_ar_ready) && (outstandingCnt < FULL_CNT);
        bus.s_ar_ready = '0;
        if (found)
            bus.s_ar_ready[winner] = can_grant;
        ar_hs = found && can_grant;
    end

    // R beats go to whoever owns the oldest outstanding grant; with nothing outstanding they are refused.
    always_comb begin
        fifo_empty    = (outstandingCnt == '0);
        head          = order_fifo[rd_ptr];
        bus.s_r_valid = '0;
        bus.m_r_ready = 1'b0;
        if (!fifo_empty) begin
            bus.s_r_valid[head] = bus.m_r_valid;
            bus.m_r_ready       = bus.s_r_ready[head];
        end
        r_pop = bus.m_r_valid && bus.m_r_ready && bus.m_r_last;
    end

    assign bus.s_r_data = bus.m_r_data;
    assign bus.s_r_last = bus.m_r_last;
    assign bus.s_r_id   = bus.m_r_id;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.m_ar_valid <= 1'b0;
            bus.m_ar_addr  <= '0;
            bus.m_ar_len   <= '0;
            bus.m_ar_id    <= '0;
            rr_ptr         <= IDX_W'(NUM_REQ-1);
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            outstandingCnt <= '0;
            errUnexpectedR <= 1'b0;
        end else begin
            if (ar_hs) begin
                bus.m_ar_valid <= 1'b1;
                bus.m_ar_addr  <= bus.s_ar_addr[winner*ADDR_BITS +: ADDR_BITS];
                bus.m_ar_len   <= bus.s_ar_len[winner*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
                bus.m_ar_id    <= bus.s_ar_id[winner*TID_WIDTH +: TID_WIDTH];
                wr_ptr         <= wr_ptr + 1'b1;
                if (!via_prio)
                    rr_ptr <= winner;
            end else if (bus.m_ar_ready) begin
                bus.m_ar_valid <= 1'b0;
            end
            if (r_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({ar_hs, r_pop})
                2'b10:   outstandingCnt <= outstandingCnt + 1'b1;
                2'b01:   outstandingCnt <= outstandingCnt - 1'b1;
                default: outstandingCnt <= outstandingCnt;
            endcase
            if (bus.m_r_valid && fifo_empty)
                errUnexpectedR <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ar_hs)
            order_fifo[wr_ptr] <= winner;
    end
endmodule

// File: tb/tb_prefetch_ar_arbiter.sv
// Directed bench for prefetch_ar_arbiter: a 2-requester priority instance and a 3-requester round-robin instance.
module tb_prefetch_ar_arbiter;
    localparam int AW   = 16;
    localparam int LW   = 8;
    localparam int IW   = 8;
    localparam int DW   = 8;
    localparam int LOGO = 2;

    logic          clk = 1'b0;
    logic          resetN;
    logic          en_a;
    logic          en_b;
    logic [LOGO:0] cnt_a;
    logic [LOGO:0] cnt_b;
    logic          err_a;
    logic          err_b;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    prefetch_ar_arbiter_if #(.NUM_REQ(2), .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW), .DATA_WIDTH(DW)) bus_a ();
    prefetch_ar_arbiter_if #(.NUM_REQ(3), .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW), .DATA_WIDTH(DW)) bus_b ();

    prefetch_ar_arbiter #(.NUM_REQ(2), .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW),
                          .DATA_WIDTH(DW), .LOG_OUTSTANDING(LOGO), .PRIO0(1)) dut_a (
        .clk(clk), .resetN(resetN), .en(en_a), .bus(bus_a.master),
        .outstandingCnt(cnt_a), .errUnexpectedR(err_a)
    );

    prefetch_ar_arbiter #(.NUM_REQ(3), .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW),
                          .DATA_WIDTH(DW), .LOG_OUTSTANDING(LOGO), .PRIO0(0)) dut_b (
        .clk(clk), .resetN(resetN), .en(en_b), .bus(bus_b.master),
        .outstandingCnt(cnt_b), .errUnexpectedR(err_b)
    );

    typedef struct {
        logic [1:0]  ar_valid;
        logic        m_ar_ready;
        logic        r_valid;
        logic        r_last;
        logic [1:0]  r_ready;
        logic [1:0]  exp_ar_ready;
        logic [1:0]  exp_r_valid;
        logic        exp_m_r_ready;
        logic        exp_m_ar_valid;
        logic [15:0] exp_m_ar_addr;
        logic [2:0]  exp_cnt;
    } vec_t;

    typedef struct {
        logic       rv;
        logic       rl;
        logic [1:0] rr;
        logic [7:0] data;
        logic [1:0] exp_sv;
        logic       exp_mr;
    } rvec_t;

    vec_t  vecs [13];
    rvec_t rvecs [7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        bus_a.s_ar_valid = '0;
        bus_a.m_ar_ready = 1'b0;
        bus_a.m_r_valid  = 1'b0;
        bus_a.m_r_last   = 1'b0;
        bus_a.m_r_data   = '0;
        bus_a.s_r_ready  = 2'b11;
        bus_b.s_ar_valid = '0;
        bus_b.m_ar_ready = 1'b0;
        bus_b.m_r_valid  = 1'b0;
        bus_b.m_r_last   = 1'b0;
        bus_b.m_r_data   = '0;
        bus_b.s_r_ready  = 3'b111;
    endtask

    task automatic applyReset();
        @(negedge clk);
        clearInputs();
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    // One table row is one clock: combinational outputs sampled before the edge, registers just after.
    task automatic applyStimulus(input vec_t v, input int row);
        @(negedge clk);
        bus_a.s_ar_valid = v.ar_valid;
        bus_a.m_ar_ready = v.m_ar_ready;
        bus_a.m_r_valid  = v.r_valid;
        bus_a.m_r_last   = v.r_last;
        bus_a.s_r_ready  = v.r_ready;
        #1;
        checkOutput($sformatf("row%0d s_ar_ready", row), 32'(bus_a.s_ar_ready), 32'(v.exp_ar_ready));
        checkOutput($sformatf("row%0d s_r_valid", row), 32'(bus_a.s_r_valid), 32'(v.exp_r_valid));
        checkOutput($sformatf("row%0d m_r_ready", row), 32'(bus_a.m_r_ready), 32'(v.exp_m_r_ready));
        @(posedge clk);
        #1;
        checkOutput($sformatf("row%0d m_ar_valid", row), 32'(bus_a.m_ar_valid), 32'(v.exp_m_ar_valid));
        checkOutput($sformatf("row%0d m_ar_addr", row), 32'(bus_a.m_ar_addr), 32'(v.exp_m_ar_addr));
        checkOutput($sformatf("row%0d outstandingCnt", row), 32'(cnt_a), 32'(v.exp_cnt));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beats1;
        // Priority + full-FIFO sequence on the 2-requester instance, starting from reset.
        vecs[0]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 1'b0, 1'b1, 16'h1000, 3'd1};
        vecs[1]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 1'b1, 16'h1000, 3'd2};
        vecs[2]  = '{2'b10, 1'b1, 1'b0, 1'b0, 2'b11, 2'b10, 2'b00, 1'b1, 1'b1, 16'h2000, 3'd3};
        vecs[3]  = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 2'b01, 2'b01, 1'b1, 1'b1, 16'h1000, 3'd3};
        vecs[4]  = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 2'b01, 2'b01, 1'b1, 1'b1, 16'h1000, 3'd3};
        vecs[5]  = '{2'b00, 1'b1, 1'b1, 1'b1, 2'b11, 2'b00, 2'b10, 1'b1, 1'b0, 16'h1000, 3'd2};
        vecs[6]  = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b11, 2'b10, 2'b00, 1'b1, 1'b1, 16'h2000, 3'd3};
        vecs[7]  = '{2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 16'h2000, 3'd3};
        vecs[8]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 1'b1, 16'h1000, 3'd4};
        vecs[9]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 16'h1000, 3'd4};
        vecs[10] = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, 16'h1000, 3'd3};
        vecs[11] = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 1'b1, 16'h1000, 3'd4};
        vecs[12] = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 16'h1000, 3'd4};

        // Requester 1 burst of 4 beats (stalled 2 cycles), then requester 0 single beat.
        rvecs[0] = '{1'b1, 1'b0, 2'b11, 8'h10, 2'b10, 1'b1};
        rvecs[1] = '{1'b1, 1'b0, 2'b01, 8'h11, 2'b10, 1'b0};
        rvecs[2] = '{1'b1, 1'b0, 2'b01, 8'h11, 2'b10, 1'b0};
        rvecs[3] = '{1'b1, 1'b0, 2'b11, 8'h11, 2'b10, 1'b1};
        rvecs[4] = '{1'b1, 1'b0, 2'b11, 8'h12, 2'b10, 1'b1};
        rvecs[5] = '{1'b1, 1'b1, 2'b11, 8'h13, 2'b10, 1'b1};
        rvecs[6] = '{1'b1, 1'b1, 2'b11, 8'h20, 2'b01, 1'b1};

        resetN          = 1'b0;
        en_a            = 1'b1;
        en_b            = 1'b1;
        bus_a.s_ar_addr = {16'h2000, 16'h1000};
        bus_a.s_ar_len  = {8'd0, 8'd0};
        bus_a.s_ar_id   = {8'hB1, 8'hA0};
        bus_a.m_r_id    = 8'h5A;
        bus_b.s_ar_addr = {16'h3200, 16'h3100, 16'h3000};
        bus_b.s_ar_len  = '0;
        bus_b.s_ar_id   = {8'hC2, 8'hC1, 8'hC0};
        bus_b.m_r_id    = 8'h00;
        clearInputs();
        applyReset();

        #1;
        checkOutput("reset m_ar_valid", 32'(bus_a.m_ar_valid), 32'd0);
        checkOutput("reset outstandingCnt", 32'(cnt_a), 32'd0);
        checkOutput("reset errUnexpectedR", 32'(err_a), 32'd0);

        for (int i = 0; i < 13; i++)
            applyStimulus(vecs[i], i);

        // Burst steering with a mid-burst stall.
        applyReset();
        bus_a.s_ar_len = {8'd3, 8'd0};
        @(negedge clk);
        bus_a.s_ar_valid = 2'b10;
        bus_a.m_ar_ready = 1'b1;
        #1;
        checkOutput("burst grant1 s_ar_ready", 32'(bus_a.s_ar_ready), 32'b10);
        @(posedge clk);
        #1;
        checkOutput("burst grant1 m_ar_len", 32'(bus_a.m_ar_len), 32'd3);
        checkOutput("burst grant1 m_ar_id", 32'(bus_a.m_ar_id), 32'hB1);
        @(negedge clk);
        bus_a.s_ar_valid = 2'b01;
        #1;
        checkOutput("burst grant0 s_ar_ready", 32'(bus_a.s_ar_ready), 32'b01);
        @(posedge clk);
        #1;
        checkOutput("burst grant0 m_ar_len", 32'(bus_a.m_ar_len), 32'd0);
        checkOutput("burst grant0 outstandingCnt", 32'(cnt_a), 32'd2);
        @(negedge clk);
        bus_a.s_ar_valid = 2'b00;
        beats1 = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            bus_a.m_r_valid = rvecs[c].rv;
            bus_a.m_r_last  = rvecs[c].rl;
            bus_a.s_r_ready = rvecs[c].rr;
            bus_a.m_r_data  = rvecs[c].data;
            #1;
            checkOutput($sformatf("rbeat%0d s_r_valid", c), 32'(bus_a.s_r_valid), 32'(rvecs[c].exp_sv));
            checkOutput($sformatf("rbeat%0d m_r_ready", c), 32'(bus_a.m_r_ready), 32'(rvecs[c].exp_mr));
            checkOutput($sformatf("rbeat%0d s_r_data", c), 32'(bus_a.s_r_data), 32'(rvecs[c].data));
            checkOutput($sformatf("rbeat%0d s_r_last", c), 32'(bus_a.s_r_last), 32'(rvecs[c].rl));
            if (bus_a.s_r_valid[1] && bus_a.s_r_ready[1])
                beats1++;
        end
        checkOutput("burst s_r_id passthrough", 32'(bus_a.s_r_id), 32'h5A);
        @(negedge clk);
        bus_a.m_r_valid = 1'b0;
        bus_a.m_r_last  = 1'b0;
        #1;
        checkOutput("burst req1 handshakes", 32'(beats1), 32'd4);
        checkOutput("burst drained outstandingCnt", 32'(cnt_a), 32'd0);

        // Unexpected R beat with nothing outstanding.
        checkOutput("errUnexpectedR before", 32'(err_a), 32'd0);
        @(negedge clk);
        bus_a.m_r_valid = 1'b1;
        bus_a.m_r_last  = 1'b1;
        #1;
        checkOutput("unexpected m_r_ready", 32'(bus_a.m_r_ready), 32'd0);
        checkOutput("unexpected s_r_valid", 32'(bus_a.s_r_valid), 32'd0);
        @(negedge clk);
        bus_a.m_r_valid = 1'b0;
        bus_a.m_r_last  = 1'b0;
        checkOutput("errUnexpectedR set", 32'(err_a), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("errUnexpectedR sticky", 32'(err_a), 32'd1);

        // Asynchronous reset with two bursts in flight.
        @(negedge clk);
        bus_a.s_ar_valid = 2'b11;
        repeat (2) @(negedge clk);
        bus_a.s_ar_valid = 2'b00;
        #1;
        checkOutput("inflight outstandingCnt", 32'(cnt_a), 32'd2);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midreset m_ar_valid", 32'(bus_a.m_ar_valid), 32'd0);
        checkOutput("midreset m_ar_addr", 32'(bus_a.m_ar_addr), 32'd0);
        checkOutput("midreset outstandingCnt", 32'(cnt_a), 32'd0);
        checkOutput("midreset errUnexpectedR", 32'(err_a), 32'd0);
        checkOutput("midreset m_r_ready", 32'(bus_a.m_r_ready), 32'd0);
        checkOutput("midreset s_ar_ready", 32'(bus_a.s_ar_ready), 32'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        bus_a.s_ar_valid = 2'b11;
        #1;
        checkOutput("postreset s_ar_ready", 32'(bus_a.s_ar_ready), 32'b01);
        @(posedge clk);
        #1;
        checkOutput("postreset m_ar_addr", 32'(bus_a.m_ar_addr), 32'h1000);
        checkOutput("postreset outstandingCnt", 32'(cnt_a), 32'd1);
        @(negedge clk);
        bus_a.s_ar_valid = 2'b00;

        // Round-robin instance: all requesters valid, one R beat per cycle keeps the FIFO at one entry.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus_b.s_ar_valid = 3'b111;
            bus_b.m_ar_ready = 1'b1;
            bus_b.m_r_valid  = (k > 0);
            bus_b.m_r_last   = 1'b1;
            #1;
            checkOutput($sformatf("rr%0d s_ar_ready", k), 32'(bus_b.s_ar_ready), 32'(1 << (k % 3)));
            if (k > 0)
                checkOutput($sformatf("rr%0d s_r_valid", k), 32'(bus_b.s_r_valid), 32'(1 << ((k - 1) % 3)));
            @(posedge clk);
            #1;
            checkOutput($sformatf("rr%0d m_ar_addr", k), 32'(bus_b.m_ar_addr), 32'(16'h3000 + (k % 3) * 16'h0100));
            checkOutput($sformatf("rr%0d outstandingCnt", k), 32'(cnt_b), 32'd1);
        end
        @(negedge clk);
        bus_b.s_ar_valid = 3'b000;
        @(negedge clk);
        bus_b.m_r_valid = 1'b0;
        checkOutput("rr drained outstandingCnt", 32'(cnt_b), 32'd0);
        checkOutput("rr m_ar_valid cleared", 32'(bus_b.m_ar_valid), 32'd0);
        checkOutput("rr errUnexpectedR", 32'(err_b), 32'd0);
        en_b = 1'b0;
        bus_b.s_ar_valid = 3'b111;
        #1;
        checkOutput("en low s_ar_ready", 32'(bus_b.s_ar_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
